// File: rtl/nubus_pkg.sv
// nubus_pkg: shared types for the NuBus master and slave sides.
// State encoding, status codes, output bundle and bus-free helper.
package nubus_pkg;

  localparam int NUBUS_TIMEOUT = 255;
  localparam int NUBUS_ARB_MIN = 2;

  typedef logic [1:0] tm_t;

  // {TM1*,TM0*} status returned with ACK*
  localparam tm_t TM_COMPLETE = 2'b00;
  localparam tm_t TM_ERROR    = 2'b01;
  localparam tm_t TM_RETRY    = 2'b10;
  localparam tm_t TM_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ADDR,
    ST_DATA,
    ST_ATTN
  } nub_state_e;

  typedef struct packed {
    logic ready;
    logic done;
    tm_t  status;
    logic timeout;
    logic arbcy;
    logic adrcy;
    logic dtacy;
    logic owner;
    logic locked;
    logic tm1n;
    logic tm0n;
  } mst_out_t;

  localparam mst_out_t MST_OUT_RST = '{
    ready:   1'b1,
    done:    1'b0,
    status:  2'b00,
    timeout: 1'b0,
    arbcy:   1'b0,
    adrcy:   1'b0,
    dtacy:   1'b0,
    owner:   1'b0,
    locked:  1'b0,
    tm1n:    1'b1,
    tm0n:    1'b1
  };

  // No START* on the bus, or an ACK* is closing the tenure
  function automatic logic bus_free(
    input logic startn,
    input logic ackn
  );
    return (startn & ackn) | ~ackn;
  endfunction

endpackage

// File: rtl/nubus_master_if.sv
// nubus_master_if: CPU request side, sampled NuBus lines
// and cycle indicators for the bus driver.
interface nubus_master_if;
  import nubus_pkg::*;

  logic cpu_valid;
  logic cpu_ready;
  logic cpu_lock;
  logic cpu_tm1n;
  logic cpu_tm0n;
  logic cpu_done;
  tm_t  cpu_status;
  logic cpu_timeout;

  logic nub_startn;
  logic nub_ackn;
  logic nub_tm1n;
  logic nub_tm0n;
  logic arb_won;

  logic mst_arbcy;
  logic mst_adrcy;
  logic mst_dtacy;
  logic mst_owner;
  logic mst_locked;
  logic mst_tm1n;
  logic mst_tm0n;

  modport master (
    input  cpu_valid, cpu_lock,
    input  cpu_tm1n, cpu_tm0n,
    output cpu_ready, cpu_done,
    output cpu_status, cpu_timeout,
    input  nub_startn, nub_ackn,
    input  nub_tm1n, nub_tm0n,
    input  arb_won,
    output mst_arbcy, mst_adrcy,
    output mst_dtacy, mst_owner,
    output mst_locked,
    output mst_tm1n, mst_tm0n
  );

  modport slave (
    output cpu_valid, cpu_lock,
    output cpu_tm1n, cpu_tm0n,
    input  cpu_ready, cpu_done,
    input  cpu_status, cpu_timeout,
    output nub_startn, nub_ackn,
    output nub_tm1n, nub_tm0n,
    output arb_won,
    input  mst_arbcy, mst_adrcy,
    input  mst_dtacy, mst_owner,
    input  mst_locked,
    input  mst_tm1n, mst_tm0n
  );

endinterface

// File: rtl/nubus_timeout_cnt.sv
// nubus_timeout_cnt: load/decrement counter with terminal flag.
// Shared by the master and slave ACK* timeout logic.
module nubus_timeout_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] value,
  output logic         term
);

  logic [W-1:0] count;

  // Load wins over decrement; count holds at zero
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= value;
    else if (dec && count != '0)
      count <= count - W'(1);
  end

  assign term = (count == '0);

endmodule

// File: rtl/nubus_master.sv
// nubus_master: NuBus master transaction sequencer.
// IDLE -> ARB -> ADDR -> DATA -> (ATTN) -> IDLE, registered outputs.
module nubus_master
  import nubus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = NUBUS_TIMEOUT,
  parameter int ARB_MIN        = NUBUS_ARB_MIN
) (
  input  logic           nub_clkn,
  input  logic           nub_resetn,
  nubus_master_if.master bus
);

  localparam logic [7:0] TO_LOAD =
    8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ARB_LIM = 8'(ARB_MIN);

  nub_state_e state_q;
  nub_state_e state_d;
  mst_out_t   out_q;
  mst_out_t   out_d;
  logic [7:0] arb_cnt;

  logic accept;
  logic free;
  logic ack;
  logic arb_ok;
  logic to_term;

  assign accept = bus.cpu_valid & out_q.ready;
  assign free   = bus_free(bus.nub_startn,
                           bus.nub_ackn);
  assign ack    = ~bus.nub_ackn;
  assign arb_ok = (arb_cnt >= ARB_LIM)
                & bus.arb_won & free;

  nubus_timeout_cnt #(
    .W(8)
  ) u_tmo (
    .clk   (nub_clkn),
    .rst_n (nub_resetn),
    .load  (state_q == ST_ADDR),
    .dec   (state_q == ST_DATA),
    .value (TO_LOAD),
    .term  (to_term)
  );

  // State and registered output bundle
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      state_q <= ST_IDLE;
      out_q   <= MST_OUT_RST;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  // Arbitration dwell counter, saturating at ARB_MIN
  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn)
      arb_cnt <= '0;
    else if (accept)
      arb_cnt <= '0;
    else if (state_q == ST_ARB
             && arb_cnt < ARB_LIM)
      arb_cnt <= arb_cnt + 8'd1;
  end

  // Next-state: ACK* is checked ahead of timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (accept) state_d = ST_ARB;
      ST_ARB:
        if (arb_ok) state_d = ST_ADDR;
      ST_ADDR:
        state_d = ST_DATA;
      ST_DATA:
        if (ack)
          state_d = out_q.locked ? ST_ATTN
                                 : ST_IDLE;
        else if (to_term)
          state_d = ST_IDLE;
      ST_ATTN:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered
  always_comb begin
    out_d       = out_q;
    out_d.ready = (state_d == ST_IDLE);
    out_d.done  = 1'b0;
    out_d.arbcy = 1'b0;
    out_d.adrcy = 1'b0;
    out_d.dtacy = 1'b0;
    out_d.owner = 1'b0;

    if (accept) begin
      out_d.locked  = bus.cpu_lock;
      out_d.tm1n    = bus.cpu_tm1n;
      out_d.tm0n    = bus.cpu_tm0n;
      out_d.timeout = 1'b0;
    end

    if (state_q == ST_DATA) begin
      if (ack) begin
        out_d.status  = {bus.nub_tm1n,
                         bus.nub_tm0n};
        out_d.timeout = 1'b0;
      end else if (to_term) begin
        out_d.status  = TM_TIMEOUT;
        out_d.timeout = 1'b1;
      end
    end

    if (state_q != ST_IDLE
        && state_d == ST_IDLE)
      out_d.done = 1'b1;

    if (state_d == ST_IDLE)
      out_d.locked = 1'b0;

    unique case (state_d)
      ST_ARB: begin
        out_d.arbcy = 1'b1;
      end
      ST_ADDR: begin
        out_d.owner = 1'b1;
        out_d.adrcy = 1'b1;
        out_d.arbcy = out_d.locked;
      end
      ST_DATA: begin
        out_d.owner = 1'b1;
        out_d.dtacy = 1'b1;
        out_d.arbcy = out_d.locked;
      end
      ST_ATTN: begin
        out_d.owner = 1'b1;
        out_d.arbcy = 1'b1;
        out_d.dtacy = 1'b1;
      end
      default: begin
        out_d.owner = 1'b0;
      end
    endcase
  end

  assign bus.cpu_ready   = out_q.ready;
  assign bus.cpu_done    = out_q.done;
  assign bus.cpu_status  = out_q.status;
  assign bus.cpu_timeout = out_q.timeout;
  assign bus.mst_arbcy   = out_q.arbcy;
  assign bus.mst_adrcy   = out_q.adrcy;
  assign bus.mst_dtacy   = out_q.dtacy;
  assign bus.mst_owner   = out_q.owner;
  assign bus.mst_locked  = out_q.locked;
  assign bus.mst_tm1n    = out_q.tm1n;
  assign bus.mst_tm0n    = out_q.tm0n;

endmodule

// File: tb/tb_nubus_master.sv
// tb_nubus_master: randomized bench with a done scoreboard
// and a per-clock phase checker for nubus_master.
module tb_nubus_master;
  import nubus_pkg::*;

  localparam int T    = NUBUS_TIMEOUT;
  localparam int AMIN = 2;

  typedef enum {
    PH_NONE, PH_RST, PH_IDLE,
    PH_ARB, PH_ADDR, PH_DATA, PH_ATTN
  } ph_e;

  typedef struct {
    int         edge_no;
    logic [1:0] status;
    logic       tmo;
  } exp_t;

  logic nub_clkn   = 1'b0;
  logic nub_resetn = 1'b0;

  nubus_master_if bus();

  nubus_master #(
    .TIMEOUT_CYCLES(T),
    .ARB_MIN(AMIN)
  ) dut (
    .nub_clkn   (nub_clkn),
    .nub_resetn (nub_resetn),
    .bus        (bus)
  );

  always #5 nub_clkn = ~nub_clkn;

  exp_t       sb[$];
  int         n_run  = 0;
  int         n_fail = 0;
  int         edge_n = 0;
  ph_e        exp_ph = PH_NONE;
  logic       exp_lock = 1'b0;
  logic [1:0] exp_tm = 2'b11;
  logic [5:0] m_got;
  logic [5:0] m_want;
  exp_t       m_e;

  always @(posedge nub_clkn) edge_n <= edge_n + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h want %0h",
               name, edge_n, act, want);
    end
  endtask

  // Monitor: per-clock phase outputs and done scoreboard
  always @(negedge nub_clkn) begin
    if (exp_ph != PH_NONE) begin
      m_got = {bus.cpu_ready, bus.mst_arbcy,
               bus.mst_adrcy, bus.mst_dtacy,
               bus.mst_owner, bus.mst_locked};
      case (exp_ph)
        PH_ARB:
          m_want = {5'b01000, exp_lock};
        PH_ADDR:
          m_want = {1'b0, exp_lock, 3'b101,
                    exp_lock};
        PH_DATA:
          m_want = {1'b0, exp_lock, 3'b011,
                    exp_lock};
        PH_ATTN:
          m_want = 6'b010111;
        default:
          m_want = 6'b100000;
      endcase
      check("phase", 32'(m_got), 32'(m_want));
      if (exp_ph == PH_RST)
        check("rst_out",
              32'({bus.cpu_done, bus.cpu_timeout,
                   bus.cpu_status, bus.mst_tm1n,
                   bus.mst_tm0n}),
              32'(6'b000011));
      else if (exp_ph != PH_IDLE)
        check("mst_tm",
              32'({bus.mst_tm1n, bus.mst_tm0n}),
              32'(exp_tm));
      if (bus.cpu_done !== 1'b0) begin
        if (sb.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL done_unexp @edge %0d: got 1 want 0",
                   edge_n);
        end else begin
          m_e = sb.pop_front();
          check("done_edge", 32'(edge_n),
                32'(m_e.edge_no));
          check("status", 32'(bus.cpu_status),
                32'(m_e.status));
          check("timeout", 32'(bus.cpu_timeout),
                32'(m_e.tmo));
        end
      end
    end
  end

  task automatic step();
    @(posedge nub_clkn);
    #1;
  endtask

  task automatic drive_bus(input logic won,
                           input logic sn,
                           input logic an,
                           input logic [1:0] tm);
    bus.arb_won    = won;
    bus.nub_startn = sn;
    bus.nub_ackn   = an;
    {bus.nub_tm1n, bus.nub_tm0n} = tm;
  endtask

  // One transaction: ka=0 means no ACK*, rk>0 resets
  // on the rk-th DATA clock instead of finishing.
  task automatic run_txn(input bit lock,
                         input logic [1:0] tm,
                         input int wd,
                         input int bd,
                         input bit rnd,
                         input int ka,
                         input logic [1:0] atm,
                         input int rk,
                         input int gap);
    logic won_a[64];
    logic sn_a[64];
    logic an_a[64];
    int   a;
    int   js;
    int   kend;
    int   d;
    bit   acked;
    bit   stop;
    exp_t e;

    repeat (gap) begin
      step();
      exp_ph = PH_IDLE;
    end

    for (int j = 0; j < 64; j++) begin
      if (j > wd)
        won_a[j] = 1'b1;
      else
        won_a[j] = rnd ? 1'($urandom_range(1)) : 1'b0;
      if (j > wd + bd) begin
        sn_a[j] = 1'b1;
        an_a[j] = 1'b1;
      end else if (rnd && $urandom_range(2) == 0) begin
        sn_a[j] = 1'($urandom_range(1));
        an_a[j] = 1'b0;
      end else if (rnd && $urandom_range(1) == 0) begin
        sn_a[j] = 1'b1;
        an_a[j] = 1'b1;
      end else begin
        sn_a[j] = 1'b0;
        an_a[j] = 1'b1;
      end
    end

    // First ARB clock past the minimum dwell with a
    // win and a free bus
    js = 0;
    for (int j = AMIN + 1; j < 64 && js == 0; j++)
      if (won_a[j] && (!an_a[j] || sn_a[j]))
        js = j;

    a     = edge_n + 1;
    acked = (rk == 0) && (ka >= 1) && (ka <= T);
    kend  = acked ? ka : T;
    d     = a + js + 1 + kend
          + ((acked && lock) ? 1 : 0);
    if (rk == 0) begin
      e = '{d, acked ? atm : 2'b11, !acked};
      sb.push_back(e);
    end

    bus.cpu_valid = 1'b1;
    bus.cpu_lock  = lock;
    {bus.cpu_tm1n, bus.cpu_tm0n} = tm;
    drive_bus(1'b0, 1'b1, 1'b1, 2'b11);
    step();
    bus.cpu_valid = 1'b0;
    bus.cpu_lock  = 1'($urandom_range(1));
    {bus.cpu_tm1n, bus.cpu_tm0n} =
      2'($urandom_range(3));
    exp_ph   = PH_ARB;
    exp_lock = lock;
    exp_tm   = tm;

    for (int j = 1; j <= js; j++) begin
      drive_bus(won_a[j], sn_a[j], an_a[j],
                2'($urandom_range(3)));
      step();
      exp_ph = (j == js) ? PH_ADDR : PH_ARB;
    end

    drive_bus(1'($urandom_range(1)), 1'b1, 1'b1,
              2'b11);
    step();
    exp_ph = PH_DATA;

    stop = 1'b0;
    for (int k = 1; k <= kend && !stop; k++) begin
      if (rk != 0 && k == rk) begin
        nub_resetn = 1'b0;
        drive_bus(1'b0, 1'b1, 1'b1, 2'b11);
        step();
        exp_ph     = PH_RST;
        nub_resetn = 1'b1;
        stop       = 1'b1;
      end else begin
        if (acked && k == ka)
          drive_bus(1'($urandom_range(1)), 1'b1,
                    1'b0, atm);
        else
          drive_bus(1'($urandom_range(1)), 1'b1,
                    1'b1, 2'($urandom_range(3)));
        step();
        if (k < kend)
          exp_ph = PH_DATA;
        else if (acked && lock)
          exp_ph = PH_ATTN;
        else
          exp_ph = PH_IDLE;
      end
    end

    drive_bus(1'b0, 1'b1, 1'b1, 2'b11);
    if (!stop && acked && lock) begin
      step();
      exp_ph = PH_IDLE;
    end
  endtask

  initial begin
    bus.cpu_valid = 1'b0;
    bus.cpu_lock  = 1'b0;
    bus.cpu_tm1n  = 1'b1;
    bus.cpu_tm0n  = 1'b1;
    drive_bus(1'b0, 1'b1, 1'b1, 2'b11);
    nub_resetn = 1'b0;
    step();
    step();
    exp_ph = PH_RST;
    nub_resetn = 1'b1;
    step();
    exp_ph = PH_IDLE;

    // lock tm wd bd rnd ka atm rk gap
    run_txn(0, 2'b01, 0, 0, 0, 2, 2'b00, 0, 1);
    run_txn(1, 2'b10, 0, 0, 0, 2, 2'b01, 0, 0);
    run_txn(0, 2'b11, 4, 3, 0, 1, 2'b10, 0, 0);
    run_txn(0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    run_txn(1, 2'b01, 1, 0, 0, 0, 2'b00, 0, 1);
    run_txn(1, 2'b10, 0, 0, 0, T, 2'b10, 0, 0);
    run_txn(0, 2'b01, 0, 0, 0, 0, 2'b00, 3, 0);
    run_txn(0, 2'b10, 0, 0, 0, 1, 2'b11, 0, 0);

    for (int i = 0; i < 25; i++) begin
      int r;
      r = int'($urandom_range(9));
      run_txn(1'($urandom_range(1)),
              2'($urandom_range(3)),
              int'($urandom_range(5)),
              int'($urandom_range(4)), 1,
              (r == 0) ? 0
                       : int'($urandom_range(8, 1)),
              2'($urandom_range(3)), 0,
              int'($urandom_range(2)));
    end

    repeat (4) begin
      step();
      exp_ph = PH_IDLE;
    end
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
